// File: rtl/audio_rdclk_sequencer.sv
// Avalon-MM sequencer that paces the audio FIFO read side. It generates a divided
// read clock and one-cycle read strobes in continuous or counted-burst mode.
module audio_rdclk_sequencer #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic        rd_clk_out,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StRunCont, StRunBurst, StStop} state_e;

  state_e           r_state, w_state_d;
  logic             r_en, r_irq_en, r_done, r_underrun, r_burst, r_rd_clk, r_rdreq, r_irq;
  logic [DIV_W-1:0] r_div, r_div_cnt, w_div_cnt_d;
  logic [CNT_W-1:0] r_blen, r_remaining, w_remaining_d;
  logic [31:0]      r_total, w_status;

  logic w_wr, w_wr_ctrl, w_wr_status, w_wr_total, w_start, w_abort, w_en_d, w_irq_en_d;
  logic w_tick, w_rise, w_rd_clk_d, w_rdreq_d, w_burst_d, w_set_done, w_set_under, w_inc;
  logic w_done_d, w_underrun_d, w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wr_ctrl      = w_wr && (address == 3'd0);
  assign w_wr_status    = w_wr && (address == 3'd3);
  assign w_wr_total     = w_wr && (address == 3'd4);
  assign w_start        = w_wr_ctrl & writedata[1];
  assign w_abort        = w_wr_ctrl & writedata[3];
  assign w_en_d         = w_wr_ctrl ? writedata[0] : r_en;
  assign w_irq_en_d     = w_wr_ctrl ? writedata[2] : r_irq_en;
  assign w_unused_wdata = ^writedata;

  assign w_tick = (r_state != StIdle) && (r_div_cnt >= r_div);
  assign w_rise = w_tick && !r_rd_clk && ((r_state == StRunCont) || (r_state == StRunBurst));

  // Set events take priority over a coincident write-1-to-clear.
  assign w_done_d     = w_set_done  | (r_done     & ~(w_wr_status & writedata[1]));
  assign w_underrun_d = w_set_under | (r_underrun & ~(w_wr_status & writedata[2]));

  always_comb begin
    w_state_d     = r_state;
    w_div_cnt_d   = r_div_cnt;
    w_rd_clk_d    = r_rd_clk;
    w_rdreq_d     = 1'b0;
    w_remaining_d = r_remaining;
    w_burst_d     = r_burst;
    w_set_done    = 1'b0;
    w_set_under   = 1'b0;
    w_inc         = 1'b0;

    if (r_state != StIdle) begin
      if (w_tick) begin
        w_div_cnt_d = '0;
        w_rd_clk_d  = ~r_rd_clk;
      end else begin
        w_div_cnt_d = r_div_cnt + 1'b1;
      end
    end

    if (w_rise) begin
      if (!fifo_empty) begin
        w_rdreq_d = 1'b1;
        w_inc     = 1'b1;
        if (r_state == StRunBurst) w_remaining_d = r_remaining - 1'b1;
      end else begin
        w_set_under = 1'b1;
      end
    end

    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          if (r_blen == '0) begin
            w_set_done = 1'b1;
          end else begin
            w_state_d     = StRunBurst;
            w_remaining_d = r_blen;
            w_burst_d     = 1'b1;
          end
        end else if (w_en_d) begin
          w_state_d = StRunCont;
          w_burst_d = 1'b0;
        end
      end
      StRunCont: if (!w_en_d) w_state_d = StStop;
      StRunBurst: if (r_remaining == '0) w_state_d = StStop;
      StStop: begin
        // Leave only with the read clock low so the codec never sees a runt pulse.
        if (!r_rd_clk || w_tick) begin
          w_state_d  = StIdle;
          w_set_done = r_burst;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_state_d == StIdle) begin
      w_div_cnt_d = '0;
      w_rd_clk_d  = 1'b0;
    end

    if (w_abort) begin
      w_state_d     = StIdle;
      w_div_cnt_d   = '0;
      w_rd_clk_d    = 1'b0;
      w_remaining_d = '0;
      w_rdreq_d     = 1'b0;
      w_inc         = 1'b0;
      w_set_done    = 1'b0;
      w_set_under   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_en        <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_burst     <= 1'b0;
      r_rd_clk    <= 1'b0;
      r_rdreq     <= 1'b0;
      r_irq       <= 1'b0;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_blen      <= '0;
      r_remaining <= '0;
      r_total     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_en        <= w_en_d;
      r_irq_en    <= w_irq_en_d;
      r_done      <= w_done_d;
      r_underrun  <= w_underrun_d;
      r_burst     <= w_burst_d;
      r_rd_clk    <= w_rd_clk_d;
      r_rdreq     <= w_rdreq_d;
      r_irq       <= w_irq_en_d & (w_done_d | w_underrun_d);
      r_div_cnt   <= w_div_cnt_d;
      r_remaining <= w_remaining_d;
      if (w_wr && (address == 3'd1)) r_div <= writedata[DIV_W-1:0];
      if (w_wr && (address == 3'd2)) r_blen <= writedata[CNT_W-1:0];
      if (w_wr_total)  r_total <= '0;
      else if (w_inc)  r_total <= r_total + 32'd1;
    end
  end

  assign fifo_rdreq = r_rdreq;
  assign rd_clk_out = r_rd_clk;
  assign busy       = (r_state != StIdle);
  assign irq        = r_irq;

  always_comb begin
    w_status               = '0;
    w_status[0]            = busy;
    w_status[1]            = r_done;
    w_status[2]            = r_underrun;
    w_status[16 +: CNT_W]  = r_remaining;
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: begin
        readdata[0] = r_en;
        readdata[2] = r_irq_en;
      end
      3'd1:    readdata[DIV_W-1:0] = r_div;
      3'd2:    readdata[CNT_W-1:0] = r_blen;
      3'd3:    readdata = w_status;
      3'd4:    readdata = r_total;
      default: readdata = '0;
    endcase
  end

endmodule

// File: doc/audio_rdclk_sequencer.md
Name: audio_rdclk_sequencer

Overview:
- Avalon-MM-controlled sequencer that generates the audio read-clock enable (rd_clk_out) and paced one-cycle read requests to the audio sample FIFO.
- Replaces software bit-banging of the read-clock PIO bit.
- Supports continuous mode and counted bursts, with underrun detection and an interrupt.
- Sits on the Nios II data master bus beside the existing PIOs and drives the AGC input FIFO read side.

Parameters:
DIV_W, 16, width of divider register and internal divide counter
CNT_W, 16, width of burst length / remaining counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address (zero read latency, no wait states)
fifo_empty  in  1  audio FIFO empty flag
fifo_rdreq  out  1  one-cycle FIFO read request
rd_clk_out  out  1  divided read clock to codec/FIFO side
busy  out  1  state != IDLE
irq  out  1  level interrupt

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. All registers clear on reset: all outputs 0, state IDLE, all counters 0.
- wr = chipselect & ~write_n. Reads of unlisted addresses return 0.
- Register map:
  - addr0 CTRL:
    - bit0 EN (continuous mode), R/W.
    - bit1 START, write-1 pulse, reads 0.
    - bit2 IRQ_EN, R/W.
    - bit3 ABORT, write-1 pulse, reads 0.
  - addr1 DIV[DIV_W-1:0], R/W. Half-period = DIV+1 clk cycles; DIV=0 gives period 2 cycles.
  - addr2 BLEN[CNT_W-1:0], R/W.
  - addr3 STATUS:
    - bit0 busy.
    - bit1 DONE, sticky, write-1-to-clear.
    - bit2 UNDERRUN, sticky, write-1-to-clear.
    - [16+CNT_W-1:16] remaining.
  - addr4 TOTAL, 32-bit count of issued fifo_rdreq; wraps at 2^32. Any write clears it; a same-cycle increment is lost.
- States: IDLE, RUN_CONT, RUN_BURST, STOP.
- Transitions:
  - IDLE → RUN_BURST on START. remaining ← BLEN. If BLEN=0, go instead directly to IDLE next cycle with DONE set and no strobes.
  - IDLE → RUN_CONT when EN=1 and no START. START in the same write as EN=1 → burst takes priority; continuous mode follows after the burst if EN is still 1.
  - RUN_CONT → STOP when EN cleared.
  - RUN_BURST → STOP in the cycle after the rdreq that makes remaining 0.
  - STOP → IDLE at the next falling toggle of rd_clk_out, or immediately if rd_clk_out=0. DONE sets on entering IDLE from a burst.
  - START while not IDLE is ignored.
  - ABORT from any state → IDLE next cycle: rd_clk_out←0, div_cnt←0, remaining←0, DONE not set. ABORT wins over START in the same write.
- Divider: in RUN_*/STOP, div_cnt increments each cycle.
  - When div_cnt >= DIV: toggle rd_clk_out and set div_cnt←0.
  - A DIV change mid-run takes effect on the current half-period via the >= compare.
  - div_cnt is held at 0 in IDLE.
  - First toggle (low→high) occurs DIV+1 cycles after leaving IDLE.
- Strobe, on each low→high toggle in RUN_*:
  - If fifo_empty=0: fifo_rdreq=1 for exactly that cycle, registered and aligned with rd_clk_out rising. TOTAL+1, and remaining−1 in burst mode.
  - If fifo_empty=1: no rdreq, UNDERRUN set, remaining unchanged (the burst retries on later edges).
  - No rdreq is ever issued in STOP or IDLE.
- A W1C write coinciding with a set event: the set wins.
- irq = IRQ_EN & (DONE | UNDERRUN), registered.
- busy = (state != IDLE).

Test Plan:
- Reset mid-burst (reset_n low while RUN_BURST, rd_clk_out=1) → all outputs 0 asynchronously; STATUS=0, TOTAL=0 after release.
- DIV=3, BLEN=4, fifo_empty=0, START → rd_clk_out period 8 cycles; first rise 4 cycles after the write; exactly 4 fifo_rdreq pulses, 8 cycles apart. Then STOP, rd_clk_out low, IDLE, STATUS=0x00000002, TOTAL=4.
- Same burst, fifo_empty=1 during the 2nd rising edge → UNDERRUN set, still 4 rdreq total (5 rising edges); with IRQ_EN=1, irq asserts; W1C 0x6 to STATUS clears irq.
- BLEN=0, START → no rdreq, DONE set within 2 cycles, busy never observed high beyond 1 cycle.
- EN=1, DIV=0 → rdreq every 2 cycles. Clear EN with rd_clk_out high → one more fall, no further rdreq, IDLE. Then ABORT mid-burst → IDLE next cycle, rd_clk_out=0, DONE=0.
- Write START while RUN_BURST with remaining=2 → ignored, exactly 2 more rdreq. Write TOTAL on a strobe cycle → TOTAL reads 0.
